// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending-write scoreboard; ports CLK, RST (async low), WrEn/WrAddress/WrData (2 write ports), RdAddress/RdData/RdBusy (NUM_RD read ports), IssueEn/IssueAddr, PendCount; RF_BYPASS_EN enables same-cycle write-to-read forwarding
module regfile_mp #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [1:0]                   WrEn,
  input  logic [2*DEPTH_BITS-1:0]      WrAddress,
  input  logic [2*WIDTH-1:0]           WrData,
  input  logic [NUM_RD*DEPTH_BITS-1:0] RdAddress,
  output logic [NUM_RD*WIDTH-1:0]      RdData,
  output logic [NUM_RD-1:0]            RdBusy,
  input  logic                         IssueEn,
  input  logic [DEPTH_BITS-1:0]        IssueAddr,
  output logic [DEPTH_BITS:0]          PendCount
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  logic [WIDTH-1:0]      rf [DEPTH];
  logic [DEPTH-1:0]      busy, busy_nx;
  logic [DEPTH_BITS:0]   pend_nx;
  logic [DEPTH_BITS-1:0] wa [2];
  logic [WIDTH-1:0]      wd [2];
  assign wa[0] = WrAddress[0 +: DEPTH_BITS];
  assign wa[1] = WrAddress[DEPTH_BITS +: DEPTH_BITS];
  assign wd[0] = WrData[0 +: WIDTH];
  assign wd[1] = WrData[WIDTH +: WIDTH];
  always_comb begin
    busy_nx = busy;
    for (int p = 0; p < 2; p++) if (WrEn[p]) busy_nx[wa[p]] = 1'b0;
    if (IssueEn && !(ZERO_REG != 0 && IssueAddr == '0)) busy_nx[IssueAddr] = 1'b1;
    pend_nx = '0;
    for (int i = 0; i < DEPTH; i++) pend_nx = pend_nx + (DEPTH_BITS+1)'(busy_nx[i]);
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      busy      <= '0;
      PendCount <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (WrEn[p] && !(ZERO_REG != 0 && wa[p] == '0)) rf[wa[p]] <= wd[p];
      busy      <= busy_nx;
      PendCount <= pend_nx;
    end
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [DEPTH_BITS-1:0] ra;
    logic z;
    assign ra = RdAddress[r*DEPTH_BITS +: DEPTH_BITS];
    assign z  = (ZERO_REG != 0) && (ra == '0);
`ifdef RF_BYPASS_EN
    logic h0, h1;
    assign h0 = WrEn[0] && (wa[0] == ra) && !z;
    assign h1 = WrEn[1] && (wa[1] == ra) && !z;
    assign RdData[r*WIDTH +: WIDTH] = z ? '0 : h1 ? wd[1] : h0 ? wd[0] : rf[ra];
    assign RdBusy[r] = !z && !h0 && !h1 && busy[ra];
`else
    assign RdData[r*WIDTH +: WIDTH] = z ? '0 : rf[ra];
    assign RdBusy[r] = !z && busy[ra];
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp, directed vectors checked by a negedge monitor
module tb_regfile_mp;
  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  WrEn;
  logic [9:0]  WrAddress;
  logic [63:0] WrData;
  logic [9:0]  RdAddress;
  logic [63:0] RdData;
  logic [1:0]  RdBusy;
  logic        IssueEn;
  logic [4:0]  IssueAddr;
  logic [5:0]  PendCount;
  int assertions = 0;
  int failures = 0;
  int          q_port [$];
  logic [31:0] q_data [$];
  logic        q_busy [$];
  logic [5:0]  q_pend [$];
  string       q_name [$];
  regfile_mp dut (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddress(WrAddress), .WrData(WrData),
    .RdAddress(RdAddress), .RdData(RdData), .RdBusy(RdBusy),
    .IssueEn(IssueEn), .IssueAddr(IssueAddr), .PendCount(PendCount)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic ie, input logic [4:0] ia, input logic [4:0] r0, input logic [4:0] r1);
    WrEn = we;
    WrAddress = {a1, a0};
    WrData = {d1, d0};
    IssueEn = ie;
    IssueAddr = ia;
    RdAddress = {r1, r0};
  endtask
  task automatic expect_rd(input int port, input logic [31:0] d, input logic b, input logic [5:0] pc, input string name);
    q_port.push_back(port);
    q_data.push_back(d);
    q_busy.push_back(b);
    q_pend.push_back(pc);
    q_name.push_back(name);
  endtask
  initial forever begin
    @(negedge CLK);
    while (q_port.size() > 0) begin
      int p;
      logic [31:0] ed;
      logic eb;
      logic [5:0] ep;
      string n;
      p = q_port.pop_front();
      ed = q_data.pop_front();
      eb = q_busy.pop_front();
      ep = q_pend.pop_front();
      n = q_name.pop_front();
      assertions++;
      if (RdData[p*32 +: 32] !== ed || RdBusy[p] !== eb || PendCount !== ep) begin
        failures++;
        $display("FAIL %s: port %0d data=%h busy=%b pend=%0d, expected data=%h busy=%b pend=%0d",
                 n, p, RdData[p*32 +: 32], RdBusy[p], PendCount, ed, eb, ep);
      end
    end
  end
  initial begin
    RST = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 9);
    expect_rd(0, 32'h0, 1'b0, 6'd0, "reset_rd5");
    tick;
    RST = 1'b1;
    drive(2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 9, 5, 9);
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 5, 9);
    expect_rd(0, 32'hDEADBEEF, 1'b0, 6'd1, "pre_reset_rd5");
    expect_rd(1, 32'h0, 1'b1, 6'd1, "pre_reset_busy9");
    tick;
    RST = 1'b0;
    expect_rd(0, 32'h0, 1'b0, 6'd0, "async_reset_rd5");
    expect_rd(1, 32'h0, 1'b0, 6'd0, "async_reset_busy9");
    tick;
    RST = 1'b1;
    drive(2'b01, 0, 32'h12345678, 0, 0, 1, 0, 0, 0);
    expect_rd(0, 32'h0, 1'b0, 6'd0, "x0_same_cycle");
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd(0, 32'h0, 1'b0, 6'd0, "x0_after");
    tick;
    drive(2'b11, 7, 32'h1111, 7, 32'h2222, 0, 0, 7, 0);
`ifdef RF_BYPASS_EN
    expect_rd(0, 32'h2222, 1'b0, 6'd0, "conflict_bypass_x7");
`else
    expect_rd(0, 32'h0, 1'b0, 6'd0, "conflict_same_cycle_x7");
`endif
    tick;
    drive(2'b11, 3, 32'hA, 4, 32'hB, 0, 0, 7, 0);
    expect_rd(0, 32'h2222, 1'b0, 6'd0, "conflict_x7");
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 3, 4);
    expect_rd(0, 32'hA, 1'b0, 6'd0, "dual_x3");
    expect_rd(1, 32'hB, 1'b0, 6'd0, "dual_x4");
    tick;
    drive(2'b00, 0, 0, 0, 0, 1, 9, 0, 9);
    expect_rd(1, 32'h0, 1'b0, 6'd0, "x9_issue_same_cycle");
    tick;
    drive(2'b01, 9, 32'h55, 0, 0, 1, 9, 9, 9);
`ifdef RF_BYPASS_EN
    expect_rd(0, 32'h55, 1'b0, 6'd1, "x9_bypass_with_issue");
`else
    expect_rd(0, 32'h0, 1'b1, 6'd1, "x9_busy");
`endif
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
    expect_rd(0, 32'h55, 1'b1, 6'd1, "x9_set_wins");
    tick;
    drive(2'b10, 0, 0, 9, 32'h77, 0, 0, 9, 9);
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
    expect_rd(0, 32'h77, 1'b0, 6'd0, "x9_cleared");
    tick;
    drive(2'b01, 10, 32'h1234, 0, 0, 1, 10, 0, 10);
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 10);
    expect_rd(1, 32'h1234, 1'b1, 6'd1, "x10_busy_old");
    tick;
    drive(2'b01, 10, 32'hCAFE, 0, 0, 0, 0, 0, 10);
`ifdef RF_BYPASS_EN
    expect_rd(1, 32'hCAFE, 1'b0, 6'd1, "x10_bypass");
`else
    expect_rd(1, 32'h1234, 1'b1, 6'd1, "x10_no_bypass");
`endif
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 10);
    expect_rd(1, 32'hCAFE, 1'b0, 6'd0, "x10_after");
    for (int i = 1; i < 32; i++) begin
      tick;
      drive(2'b00, 0, 0, 0, 0, 1, 5'(i), 0, 0);
    end
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 31, 0);
    expect_rd(0, 32'h0, 1'b1, 6'd31, "cap_full");
    for (int k = 0; k < 16; k++) begin
      tick;
      if (k < 15) drive(2'b11, 5'(2*k+1), 32'(256+2*k+1), 5'(2*k+2), 32'(256+2*k+2), 0, 0, 5'(2*k-1), 0);
      else drive(2'b01, 5'(2*k+1), 32'(256+2*k+1), 0, 0, 0, 0, 5'(2*k-1), 0);
      if (k > 0) expect_rd(0, 32'(256+2*k-1), 1'b0, 6'(31-2*k), "cap_retire");
    end
    tick;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 31, 0);
    expect_rd(0, 32'h11F, 1'b0, 6'd0, "cap_empty");
    tick;
    @(negedge CLK);
    #1;
    if (q_port.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q_port.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32I core and its successors: configurable width, depth and read-port count, two write ports, and a per-register scoreboard of pending writes. The decode stage reads operands and reserves destination registers; the execute and load writeback paths retire results through the two write ports. Stall logic uses the per-port busy flags, so multi-cycle units (loads, future mul/div) can be interlocked without external tracking.

## Interface
- WIDTH, 32, data width of each register
- DEPTH_BITS, 5, address width; DEPTH = 2**DEPTH_BITS registers
- NUM_RD, 2, number of read ports; legal 1..4
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy; 0 = register 0 is ordinary
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-low reset
- WrEn  input  2  per write-port enable; bit p selects port p
- WrAddress  input  2*DEPTH_BITS  port p address in bits [p*DEPTH_BITS +: DEPTH_BITS]
- WrData  input  2*WIDTH  port p data in bits [p*WIDTH +: WIDTH]
- RdAddress  input  NUM_RD*DEPTH_BITS  packed read addresses, port r in slice r
- RdData  output  NUM_RD*WIDTH  packed read data, port r in slice r
- RdBusy  output  NUM_RD  bit r = register at RdAddress slice r has a pending write
- IssueEn  input  1  reserve IssueAddr as pending destination
- IssueAddr  input  DEPTH_BITS  register to mark busy
- PendCount  output  DEPTH_BITS+1  number of registers currently busy

## Operation
- Storage: DEPTH x WIDTH register array plus DEPTH-bit busy vector.
- Write: on the rising CLK edge, for each p with WrEn[p]=1, RF[WrAddress_p] <= WrData_p.
- Write conflict: both ports enabled to the same address -> port 1 data is stored; port 0 is dropped.
- Read: RdData_r = RF[RdAddress_r]; combinational. With ZERO_REG=1 and address 0, the result is 0.
- Scoreboard set: IssueEn=1 sets busy[IssueAddr] on the edge. It is ignored when ZERO_REG=1 and IssueAddr=0.
- Scoreboard clear: any enabled write to address a clears busy[a] on the same edge.
- Set and clear of the same register in the same cycle: set wins, because the new reservation supersedes the retiring one.
- Issuing an already-busy register leaves it busy. A write to a non-busy register is legal and does not change busy.
- RdBusy_r = busy[RdAddress_r]. It is 0 for address 0 when ZERO_REG=1.
- PendCount = popcount(busy), registered, and updated on the same edge as busy.

## Timing
- Reset (RST low, asynchronous): all RF entries 0, busy all 0, PendCount 0. RdData and RdBusy settle combinationally to 0.
- Write-to-read latency: 1 cycle. Data written at edge N is visible on RdData after edge N.
- Issue-to-busy latency: 1 cycle. Clear-to-not-busy latency: 1 cycle, without bypass.
- Reset asserted mid-operation discards pending writes and reservations immediately. The first edge after release behaves normally.
- No internal state machine besides the arrays. Every output is a function of the current state and inputs, with no extra pipeline stage.

## Configuration
- RF_BYPASS_EN defined: write-to-read forwarding in the same cycle.
  - If WrEn[p] and WrAddress_p equals RdAddress_r (and the address is not 0 when ZERO_REG=1), RdData_r = WrData_p. Port 1 has priority over port 0.
  - RdBusy_r is forced to 0 in that cycle, even if an issue to the same register is also present.
- RF_BYPASS_EN undefined: reads return array contents only. RdBusy reflects the registered busy vector; the consumer stalls one extra cycle after writeback.

## Test plan
- Reset: load RF[5]=0xDEADBEEF, assert RST low mid-cycle -> RdData for address 5 = 0 at once, PendCount = 0, RdBusy = 0.
- Zero register (ZERO_REG=1): write 0x12345678 to x0 on port 0, IssueEn with IssueAddr=0 -> RdData for x0 = 0, RdBusy = 0, PendCount = 0.
- Dual-write conflict: port 0 writes x7=0x1111, port 1 writes x7=0x2222 in the same cycle -> next cycle x7 reads 0x2222. Port 0 writes x3=0xA while port 1 writes x4=0xB -> both stored.
- Scoreboard: issue x9 -> RdBusy for x9 = 1 and PendCount = 1 next cycle. Write x9=0x55 while IssueEn targets x9 in the same cycle -> x9 stays busy, data = 0x55, PendCount = 1. A second write -> busy cleared, PendCount = 0.
- Bypass (RF_BYPASS_EN): x10 busy, port 0 writes x10=0xCAFE while read port 1 addresses x10 -> same cycle RdData = 0xCAFE, RdBusy = 0. Without the macro: old value, RdBusy = 1, and 0xCAFE with RdBusy = 0 the next cycle.
- Capacity: issue all 31 non-zero registers -> PendCount = 31. Retire two per cycle on both ports -> PendCount decrements by 2 per cycle to 0.
